key_schedule: RTL and testbench
===============================

Name: key_schedule

Overview:
- Iterative AES-128 key expansion controller: accepts a 128-bit cipher key and computes all 11 round keys, one round per two clocks.
- Stores the round keys in an internal 11-entry register file.
- Serves the round keys to the downstream encryption datapath through a registered read port addressed by round number.
- Sits between key load and the cipher round logic.

Parameters:
- None. AES-128 is fixed: 10 expansion rounds, 11 stored keys, 128-bit keys.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- key_valid  in  1  key_in is presented for loading
- key_ready  out  1  block can accept a key (IDLE or DONE)
- key_in  in  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0]
- rk_addr  in  4  round-key index, 0..10
- rk_out  out  128  registered round key for rk_addr
- busy  out  1  expansion in progress
- keys_ready  out  1  all 11 round keys valid; sticky until next accept or reset

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is synchronous and active-high on rst.
- Reset values (rst=1 at an edge):
  - state=IDLE, round counter=0, all 11 key slots=0.
  - rk_out=0, busy=0, keys_ready=0, key_ready=1.
  - rst overrides everything, including mid-expansion; a partial schedule is discarded and slots are zeroed.
- States: IDLE, SUB, XOR, DONE.
  - key_ready = (state==IDLE || state==DONE).
  - busy = (state==SUB || state==XOR).
- Accept (edge where key_valid && key_ready):
  - slot[0] <= key_in; working key <= key_in; round <= 0.
  - keys_ready <= 0; state <= SUB.
  - An accept in DONE restarts expansion and discards the old schedule.
  - key_valid is ignored while busy.
- SUB state (one cycle):
  - RotWord(w3) = {w3[23:0], w3[31:24]} is applied byte-wise to four S-box lookups.
  - The S-box result is registered, so it is available in the following cycle.
  - state <= XOR.
- XOR state (one cycle), with t = registered SubWord result and rcon[round] in the top byte:
  - n0 = w0 ^ t ^ {rcon,24'h0}
  - n1 = n0 ^ w1
  - n2 = n1 ^ w2
  - n3 = n2 ^ w3
  - slot[round+1] <= {n0,n1,n2,n3}; working key <= same.
  - If round==9: state <= DONE and keys_ready <= 1 on the same edge.
  - Otherwise: round <= round+1 and state <= SUB.
- Rcon by round 0..9: 01,02,04,08,10,20,40,80,1b,36. Round values 10..15 are unreachable; if decoded, rcon=00.
- Latency:
  - Accept edge = T0.
  - Slot k is written at edge T0+2k.
  - keys_ready is high after edge T0+20.
  - A back-to-back accept is possible at edge T0+20+1 at the earliest.
- Read port:
  - Every edge: rk_out <= (rk_addr<=10) ? slot[rk_addr] : 0.
  - Read latency is 1 cycle. Reads are allowed in any state.
  - During expansion, rk_out returns current slot contents; these are defined but only meaningful when keys_ready=1.
- Simultaneous events:
  - A read of slot k on the same edge slot k is written returns the old contents.
  - rst with key_valid on the same edge: reset wins, no accept.
- S-box:
  - Standard AES forward S-box, four instances or one shared table.
  - Must be registered with exactly 1-cycle latency to match the SUB/XOR timing above.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst 2 cycles.
  - Required: key_ready=1, busy=0, keys_ready=0; rk_out=0 for rk_addr=0..10 and for rk_addr=15.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - Required: keys_ready rises exactly 20 cycles after accept.
  - rk_addr=0 -> 2b7e151628aed2a6abf7158809cf4f3c
  - rk_addr=1 -> a0fafe1788542cb123a339392a6c7605
  - rk_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
- All-zero key:
  - rk_addr=1 -> 62636363626363636263636362636363
  - rk_addr=10 -> b4ef5bcb3e92e21123e951cf6f8f188e
- key_valid during busy:
  - Stimulus: present the all-zero key at T0+5 while expanding the FIPS key.
  - Required: ignored; the final schedule matches the FIPS vectors.
- Reset mid-operation:
  - Stimulus: rst at T0+9.
  - Required: all slots read 0, state IDLE, keys_ready=0.
  - A new accept afterwards produces a correct full schedule.
- Reload from DONE:
  - Stimulus: after the FIPS schedule completes, accept the zero key.
  - Required: keys_ready drops on the accept edge and re-rises 20 cycles later with the zero-key vectors.

Source files
------------

// File: rtl/key_schedule_if.sv
// Key-load and round-key read bus between the key schedule and its client.
interface key_schedule_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic [3:0]   rk_addr;
    logic [127:0] rk_out;
    logic         busy;
    logic         keys_ready;

    modport master (
        output key_valid, key_in, rk_addr,
        input  key_ready, rk_out, busy, keys_ready
    );

    modport slave (
        input  key_valid, key_in, rk_addr,
        output key_ready, rk_out, busy, keys_ready
    );
endinterface

// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion: one round per SUB/XOR pair, 11 round keys
// held in a register file and served through a 1-cycle registered read port.
module key_schedule_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module key_schedule (
    input  logic          clk,
    input  logic          rst,
    key_schedule_if.slave ks
);
    typedef enum logic [1:0] {IDLE, SUB, XOR, DONE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [127:0]  wkey_q, wkey_d;
    logic [31:0]   sub_q, sub_d;
    logic [127:0]  slot_q [0:10];
    logic [127:0]  slot_d [0:10];
    logic [127:0]  rk_out_q, rk_out_d;
    logic          keys_ready_q, keys_ready_d;

    logic          accept;
    logic [31:0]   rot_w, sbox_y;
    logic [7:0]    rcon;
    logic [31:0]   n0, n1, n2, n3;

    assign ks.key_ready  = (state_q == IDLE) || (state_q == DONE);
    assign ks.busy       = (state_q == SUB) || (state_q == XOR);
    assign ks.keys_ready = keys_ready_q;
    assign ks.rk_out     = rk_out_q;
    assign accept        = ks.key_valid && ks.key_ready;

    // RotWord of w3 feeds the four byte lookups directly
    assign rot_w = {wkey_q[23:0], wkey_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        key_schedule_sbox u_sbox (
            .a (rot_w[8*g +: 8]),
            .y (sbox_y[8*g +: 8])
        );
    end

    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign n0 = wkey_q[127:96] ^ sub_q ^ {rcon, 24'h0};
    assign n1 = n0 ^ wkey_q[95:64];
    assign n2 = n1 ^ wkey_q[63:32];
    assign n3 = n2 ^ wkey_q[31:0];

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        wkey_d       = wkey_q;
        sub_d        = sub_q;
        keys_ready_d = keys_ready_q;
        slot_d       = slot_q;
        rk_out_d     = '0;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    slot_d[0]    = ks.key_in;
                    wkey_d       = ks.key_in;
                    round_d      = 4'd0;
                    keys_ready_d = 1'b0;
                    state_d      = SUB;
                end
            end
            SUB: begin
                sub_d   = sbox_y;
                state_d = XOR;
            end
            XOR: begin
                for (int k = 1; k <= 10; k++) begin
                    if (4'(round_q + 4'd1) == 4'(k)) slot_d[k] = {n0, n1, n2, n3};
                end
                wkey_d = {n0, n1, n2, n3};
                if (round_q == 4'd9) begin
                    state_d      = DONE;
                    keys_ready_d = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = SUB;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read sees pre-edge contents, so a same-edge write returns old data
        for (int i = 0; i <= 10; i++) begin
            if (ks.rk_addr == 4'(i)) rk_out_d = slot_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            round_q      <= 4'd0;
            wkey_q       <= '0;
            sub_q        <= '0;
            keys_ready_q <= 1'b0;
            rk_out_q     <= '0;
            for (int i = 0; i <= 10; i++) slot_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            wkey_q       <= wkey_d;
            sub_q        <= sub_d;
            keys_ready_q <= keys_ready_d;
            rk_out_q     <= rk_out_d;
            for (int i = 0; i <= 10; i++) slot_q[i] <= slot_d[i];
        end
    end
endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule using FIPS-197 and all-zero key vectors.
module tb_key_schedule;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_schedule_if ks_if ();

    key_schedule dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic read_rk(input logic [3:0] addr, output logic [127:0] val);
        ks_if.rk_addr = addr;
        @(posedge clk);
        #1 val = ks_if.rk_out;
    endtask

    // Leaves the caller 1ns after the accept edge T0
    task automatic load_key(input logic [127:0] key);
        ks_if.key_valid = 1'b1;
        ks_if.key_in    = key;
        @(posedge clk);
        #1 ks_if.key_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ks_if.keys_ready && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic check_fips(input string pfx);
        logic [127:0] v;
        read_rk(4'd0, v);  chk({pfx, "_rk0"}, v, FIPS_K);
        read_rk(4'd1, v);  chk({pfx, "_rk1"}, v, FIPS_R1);
        read_rk(4'd2, v);  chk({pfx, "_rk2"}, v, FIPS_R2);
        read_rk(4'd10, v); chk({pfx, "_rk10"}, v, FIPS_R10);
    endtask

    task automatic check_zero(input string pfx);
        logic [127:0] v;
        read_rk(4'd0, v);  chk({pfx, "_rk0"}, v, 128'h0);
        read_rk(4'd1, v);  chk({pfx, "_rk1"}, v, ZERO_R1);
        read_rk(4'd2, v);  chk({pfx, "_rk2"}, v, ZERO_R2);
        read_rk(4'd10, v); chk({pfx, "_rk10"}, v, ZERO_R10);
    endtask

    initial begin
        logic [127:0] v;
        int           cyc;

        ks_if.key_valid = 1'b0;
        ks_if.key_in    = '0;
        ks_if.rk_addr   = '0;

        // reset then idle
        do_reset(2);
        chk("rst_key_ready",  128'(ks_if.key_ready),  128'd1);
        chk("rst_busy",       128'(ks_if.busy),       128'd0);
        chk("rst_keys_ready", 128'(ks_if.keys_ready), 128'd0);
        for (int a = 0; a <= 10; a++) begin
            read_rk(4'(a), v);
            chk($sformatf("rst_rk%0d", a), v, 128'h0);
        end
        read_rk(4'd15, v); chk("rst_rk15", v, 128'h0);

        // FIPS-197 key
        load_key(FIPS_K);
        chk("fips_busy",   128'(ks_if.busy),      128'd1);
        chk("fips_kready", 128'(ks_if.key_ready), 128'd0);
        wait_ready(cyc);
        chk("fips_latency", 128'(cyc), 128'd20);
        chk("fips_done_kready", 128'(ks_if.key_ready), 128'd1);
        check_fips("fips");
        read_rk(4'd15, v); chk("fips_rk15", v, 128'h0);

        // reload from DONE with the zero key
        load_key(128'h0);
        chk("reload_keys_ready_drop", 128'(ks_if.keys_ready), 128'd0);
        wait_ready(cyc);
        chk("reload_latency", 128'(cyc), 128'd20);
        check_zero("reload");

        // key_valid during busy is ignored
        do_reset(1);
        load_key(FIPS_K);
        repeat (4) @(posedge clk);
        ks_if.key_valid = 1'b1;
        ks_if.key_in    = 128'h0;
        @(posedge clk);
        #1 ks_if.key_valid = 1'b0;
        chk("busy_ign_busy", 128'(ks_if.busy), 128'd1);
        wait_ready(cyc);
        chk("busy_ign_latency", 128'(cyc), 128'd15);
        check_fips("busy_ign");

        // reset mid-expansion at T0+9
        do_reset(1);
        load_key(FIPS_K);
        repeat (8) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_busy",       128'(ks_if.busy),       128'd0);
        chk("midrst_key_ready",  128'(ks_if.key_ready),  128'd1);
        chk("midrst_keys_ready", 128'(ks_if.keys_ready), 128'd0);
        for (int a = 0; a <= 10; a++) begin
            read_rk(4'(a), v);
            chk($sformatf("midrst_rk%0d", a), v, 128'h0);
        end
        load_key(128'h0);
        wait_ready(cyc);
        chk("midrst_latency", 128'(cyc), 128'd20);
        check_zero("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
